// File: rtl/led_pkg.sv
// Shared types and constants for the status LED blink-code driver.
// State encoding, default dwell lengths, and the assist-level width.
package led_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ON,
        OFF,
        GAP,
        ACK
    } led_state_t;

    localparam int unsigned LVL_W       = 2;
    localparam int unsigned ON_CYC_DEF  = 5_000_000;
    localparam int unsigned OFF_CYC_DEF = 5_000_000;
    localparam int unsigned GAP_CYC_DEF = 25_000_000;
    localparam int unsigned ACK_CYC_DEF = 10_000_000;

    // Timer width that holds (max_dw - 1); never narrower than one bit.
    function automatic int unsigned tmr_w(input int unsigned max_dw);
        return (max_dw > 1) ? $clog2(max_dw) : 1;
    endfunction

endpackage

// File: rtl/dwell_tmr.sv
// Loadable down-counter for state dwell timing; done is high while count is zero.
// Latency: loaded value visible the cycle after load; no backpressure.
module dwell_tmr #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/led_pattern_drv.sv
// Status LED driver: assist level as N-blink code plus gap; ack pulse gives a solid flash.
// Latency: led/busy registered, one clk after the deciding inputs; no backpressure.
module led_pattern_drv
    import led_pkg::*;
#(
    parameter int unsigned ON_CYC  = ON_CYC_DEF,
    parameter int unsigned OFF_CYC = OFF_CYC_DEF,
    parameter int unsigned GAP_CYC = GAP_CYC_DEF,
    parameter int unsigned ACK_CYC = ACK_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [LVL_W-1:0] level,
    input  logic             ack,
    output logic             led,
    output logic             busy
);

    localparam int unsigned MAX_A  = (ON_CYC  > OFF_CYC) ? ON_CYC  : OFF_CYC;
    localparam int unsigned MAX_B  = (GAP_CYC > ACK_CYC) ? GAP_CYC : ACK_CYC;
    localparam int unsigned MAX_DW = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned TW     = tmr_w(MAX_DW);

    localparam logic [TW-1:0] ON_LD  = TW'(ON_CYC  - 1);
    localparam logic [TW-1:0] OFF_LD = TW'(OFF_CYC - 1);
    localparam logic [TW-1:0] GAP_LD = TW'(GAP_CYC - 1);
    localparam logic [TW-1:0] ACK_LD = TW'(ACK_CYC - 1);

    led_state_t       state_q, state_d;
    logic [LVL_W-1:0] cnt_q, cnt_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_done;
    logic             led_q, busy_q;

    dwell_tmr #(.W(TW)) u_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lvl_q   <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            led_q   <= (state_d == ON) || (state_d == ACK);
            busy_q  <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lvl_d    = lvl_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (!en) begin
            // Loading zero clears the timer so the next code starts clean.
            state_d  = IDLE;
            cnt_d    = '0;
            tmr_load = 1'b1;
        end else if (ack) begin
            state_d  = ACK;
            tmr_load = 1'b1;
            tmr_val  = ACK_LD;
        end else begin
            case (state_q)
                IDLE: begin
                    if (level != '0) begin
                        state_d  = ON;
                        cnt_d    = LVL_W'(1);
                        lvl_d    = level;
                        tmr_load = 1'b1;
                        tmr_val  = ON_LD;
                    end
                end
                ON: begin
                    if (tmr_done) begin
                        state_d  = OFF;
                        tmr_load = 1'b1;
                        tmr_val  = OFF_LD;
                    end
                end
                OFF: begin
                    if (tmr_done) begin
                        tmr_load = 1'b1;
                        if (cnt_q < lvl_q) begin
                            state_d = ON;
                            cnt_d   = cnt_q + LVL_W'(1);
                            tmr_val = ON_LD;
                        end else begin
                            state_d = GAP;
                            tmr_val = GAP_LD;
                        end
                    end
                end
                GAP: begin
                    if (tmr_done) begin
                        if (level != '0) begin
                            state_d  = ON;
                            cnt_d    = LVL_W'(1);
                            lvl_d    = level;
                            tmr_load = 1'b1;
                            tmr_val  = ON_LD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                ACK: begin
                    if (tmr_done) begin
                        state_d  = GAP;
                        lvl_d    = level;
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LD;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign led  = led_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_led_pattern_drv.sv
// Randomized and directed checks of led_pattern_drv against a positional blink-code model.
module tb_led_pattern_drv;

    localparam int TB_ON  = 3;
    localparam int TB_OFF = 2;
    localparam int TB_GAP = 6;
    localparam int TB_ACK = 4;
    localparam int BLINK  = TB_ON + TB_OFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] level = 2'd0;
    logic       ack = 1'b0;
    logic       led;
    logic       busy;

    int checks = 0;
    int fails  = 0;
    bit cmp_on = 1'b0;

    led_pattern_drv #(
        .ON_CYC  (TB_ON),
        .OFF_CYC (TB_OFF),
        .GAP_CYC (TB_GAP),
        .ACK_CYC (TB_ACK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .level (level),
        .ack   (ack),
        .led   (led),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Model: either idle, inside an ack flash (index m_k), or at position m_p of
    // a code of m_L blinks followed by the gap (m_L = 0 means gap only).
    bit m_idle   = 1'b1;
    bit m_in_ack = 1'b0;
    int m_k = 0;
    int m_L = 0;
    int m_p = 0;

    function automatic logic m_led();
        return !m_idle && (m_in_ack || (m_p < m_L * BLINK && (m_p % BLINK) < TB_ON));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle = 1'b1; m_in_ack = 1'b0; m_k = 0; m_L = 0; m_p = 0;
        end else if (!en) begin
            m_idle = 1'b1; m_in_ack = 1'b0;
        end else if (ack) begin
            m_idle = 1'b0; m_in_ack = 1'b1; m_k = 0;
        end else if (m_in_ack) begin
            if (m_k < TB_ACK - 1) m_k++;
            else begin m_in_ack = 1'b0; m_L = 0; m_p = 0; end
        end else if (m_idle) begin
            if (level != 0) begin m_idle = 1'b0; m_L = int'(level); m_p = 0; end
        end else if (m_p < m_L * BLINK + TB_GAP - 1) begin
            m_p++;
        end else if (level != 0) begin
            m_L = int'(level); m_p = 0;
        end else begin
            m_idle = 1'b1;
        end
    end

    task automatic chk(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0b expected %0b", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on && rst_n) begin
            chk("model_led", led, m_led());
            chk("model_busy", busy, !m_idle);
        end
    end

    // Literal waveform check: one char per following cycle; also pins the model.
    task automatic expect_seq(input string name, input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            chk(name, led, s[i] == 8'h31);
            chk({name, "_model"}, m_led(), s[i] == 8'h31);
        end
    endtask

    task automatic go_idle();
        en = 1'b0; ack = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // Reset held with the block enabled and a nonzero level.
        en = 1'b1; level = 2'd2;
        repeat (3) @(negedge clk);
        chk("rst_led", led, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        cmp_on = 1'b1;
        expect_seq("rst_first", "11");
        #2 rst_n = 1'b0;
        #1 chk("rst_async_led", led, 1'b0);
        chk("rst_async_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Level 2 from idle: two full periods of 16.
        go_idle();
        en = 1'b1; level = 2'd2;
        expect_seq("lvl2", "11100111000000001110011100000000");
        chk("lvl2_busy", busy, 1'b1);

        // Level change during the second blink takes effect next period.
        go_idle();
        en = 1'b1; level = 2'd2;
        expect_seq("lvlchg_a", "111001");
        level = 2'd3;
        expect_seq("lvlchg_b", "1100000000111001110011100000000");

        // Ack during OFF, then resume with the latched level.
        go_idle();
        en = 1'b1; level = 2'd2;
        expect_seq("ackoff_a", "1110");
        ack = 1'b1;
        expect_seq("ackoff_b", "1");
        ack = 1'b0;
        expect_seq("ackoff_c", "1110000001110011100000000");

        // Retriggered ack with level 0 ends in IDLE.
        go_idle();
        en = 1'b1; level = 2'd0;
        @(negedge clk);
        ack = 1'b1;
        expect_seq("retrig_a", "1");
        ack = 1'b0;
        expect_seq("retrig_b", "1");
        ack = 1'b1;
        expect_seq("retrig_c", "1");
        ack = 1'b0;
        expect_seq("retrig_d", "111000000");
        chk("retrig_gap_busy", busy, 1'b1);
        @(negedge clk);
        chk("retrig_idle_busy", busy, 1'b0);

        // en drop with simultaneous ack, then acks while disabled.
        level = 2'd1;
        expect_seq("enack_a", "11");
        en = 1'b0; ack = 1'b1;
        @(negedge clk);
        chk("enack_led", led, 1'b0);
        chk("enack_busy", busy, 1'b0);
        for (int i = 0; i < 6; i++) begin
            ack = i[0];
            @(negedge clk);
            chk("dis_ack_led", led, 1'b0);
        end
        ack = 1'b0;

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 29) == 0) level = 2'($urandom_range(0, 3));
            ack = ($urandom_range(0, 49) == 0);
            @(negedge clk);
        end

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
